alu: RTL and testbench

Sequential 16-bit ALU for the 16-bit general-purpose processor datapath. It takes an opcode and two operands over a shared 16-bit input bus on consecutive cycles and executes one of 15 operations. It returns a 16-bit result and NZCV flags with a one-cycle `finish` pulse. Multiply, divide and shifts are iterative; the other operations complete in one execute cycle.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_muldiv_seq.sv | 83 ++++++++
 rtl/alu.sv | 201 ++++++++++++++++++++
 tb/tb_alu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit sequential ALU: datapath width, opcodes and FSM state encoding.
// Also holds helpers that classify opcodes as shift or multiply/divide operations.
package alu_pkg;

  localparam int unsigned W = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_RSR = 4'd7;
  localparam logic [3:0] OP_RSL = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;
  localparam logic [3:0] OP_OR  = 4'd10;
  localparam logic [3:0] OP_XOR = 4'd11;
  localparam logic [3:0] OP_NOT = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_TST = 4'd14;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD_B = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_ITER   = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  function automatic logic isShift(input logic [3:0] op);
    return (op == OP_LSR) || (op == OP_LSL) || (op == OP_RSR) || (op == OP_RSL);
  endfunction

  function automatic logic isMulDiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative 16-cycle unsigned multiplier (shift-add) and divider (restoring).
// A start pulse loads the operands; done pulses for one cycle after the 16th iteration.
module alu_muldiv_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  input  logic         i_start,
  input  logic         i_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_prodLo,
  output logic [W-1:0] o_prodHi,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);

  logic         r_busy;
  logic         r_div;
  logic         r_done;
  logic [4:0]   r_cnt;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_q;
  logic [W-1:0] r_b;
  logic [W:0]   w_mulSum;
  logic [W:0]   w_shifted;
  logic [W:0]   w_diff;

  // r_acc/r_q hold {high, low} of the product or {remainder, quotient}.
  always_comb begin
    w_mulSum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_shifted = {r_acc, r_q[W-1]};
    w_diff    = w_shifted - {1'b0, r_b};
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_div  <= i_div;
        r_cnt  <= 5'd16;
        r_acc  <= '0;
        r_q    <= i_a;
        r_b    <= i_b;
      end else if (r_busy) begin
        if (r_div) begin
          // A zero divisor always "fits", yielding all-ones quotient and remainder A.
          if (!w_diff[W]) begin
            r_acc <= w_diff[W-1:0];
            r_q   <= {r_q[W-2:0], 1'b1};
          end else begin
            r_acc <= w_shifted[W-1:0];
            r_q   <= {r_q[W-2:0], 1'b0};
          end
        end else begin
          {r_acc, r_q} <= {w_mulSum, r_q[W-1:1]};
        end
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_prodLo    = r_q;
  assign o_prodHi    = r_acc;
  assign o_quotient  = r_q;
  assign o_remainder = r_acc;

endmodule

// File: rtl/alu.sv
// Sequential 16-bit ALU: opcode and A on the start cycle, B on the next; registered result, NZCV and finish pulse.
// Define ALU_MULDIV_EN to build the iterative multiply/divide unit; otherwise opcodes 2-4 act as reserved ops.
module alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [3:0]   s,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         finish,
  output logic         negative,
  output logic         zero,
  output logic         carry,
  output logic         overflow
);

  state_t       r_state;
  logic [3:0]   r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_shv;
  logic [3:0]   r_cnt;
  logic         r_lastOut;
  logic [W-1:0] r_out;
  logic         r_n, r_z, r_c, r_v;

  logic [W:0]   w_sum;
  logic [W:0]   w_dif;
  logic [W-1:0] w_res;
  logic [W-1:0] w_out;
  logic         w_c, w_v, w_n, w_z;
  logic         w_hideOut, w_noNz;
  logic [W-1:0] w_shNext;
  logic         w_shOut;
  logic         w_isMd, w_mdDone, w_toIter, w_enterDone;

`ifdef ALU_MULDIV_EN
  logic [W-1:0] w_mdLo, w_mdHi, w_mdQuo, w_mdRem;

  assign w_isMd = isMulDiv(r_op);

  alu_muldiv_seq u_muldiv (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_start     ((r_state == S_EXEC) && w_isMd),
    .i_div       (r_op != OP_MUL),
    .i_a         (r_a),
    .i_b         (r_b),
    .o_done      (w_mdDone),
    .o_prodLo    (w_mdLo),
    .o_prodHi    (w_mdHi),
    .o_quotient  (w_mdQuo),
    .o_remainder (w_mdRem)
  );
`else
  assign w_isMd   = 1'b0;
  assign w_mdDone = 1'b0;
`endif

  // Result and flags for whatever op is completing; only latched on the edge that enters DONE.
  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_dif     = {1'b0, r_a} - {1'b0, r_b};
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_hideOut = 1'b0;
    w_noNz    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      OP_SUB, OP_CMP: begin
        w_res     = w_dif[W-1:0];
        w_c       = ~w_dif[W];
        w_v       = (r_a[W-1] != r_b[W-1]) && (w_dif[W-1] != r_a[W-1]);
        w_hideOut = (r_op == OP_CMP);
      end
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        w_res = w_mdLo;
        w_c   = |w_mdHi;
        w_v   = |w_mdHi;
      end
      OP_DIV: begin
        w_res = w_mdQuo;
        w_v   = (r_b == '0);
      end
      OP_MOD: begin
        w_res = w_mdRem;
        w_v   = (r_b == '0);
      end
`else
      OP_MUL, OP_DIV, OP_MOD: begin
        w_noNz = 1'b1;
        w_v    = 1'b1;
      end
`endif
      OP_LSR, OP_LSL, OP_RSR, OP_RSL: begin
        w_res = r_shv;
        w_c   = r_lastOut;
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_b;
      OP_TST: begin
        w_res     = r_a & r_b;
        w_hideOut = 1'b1;
      end
      default: w_noNz = 1'b1;
    endcase
    w_out = w_hideOut ? '0 : w_res;
    w_n   = !w_noNz && w_res[W-1];
    w_z   = !w_noNz && (w_res == '0);
  end

  always_comb begin
    w_shNext = r_shv;
    w_shOut  = 1'b0;
    case (r_op)
      OP_LSR: begin w_shNext = {1'b0, r_shv[W-1:1]};      w_shOut = r_shv[0];   end
      OP_LSL: begin w_shNext = {r_shv[W-2:0], 1'b0};      w_shOut = r_shv[W-1]; end
      OP_RSR: begin w_shNext = {r_shv[0], r_shv[W-1:1]};  w_shOut = r_shv[0];   end
      OP_RSL: begin w_shNext = {r_shv[W-2:0], r_shv[W-1]}; w_shOut = r_shv[W-1]; end
      default: ;
    endcase
  end

  assign w_toIter    = (r_state == S_EXEC) && (isShift(r_op) || w_isMd);
  assign w_enterDone = ((r_state == S_EXEC) && !w_toIter) ||
                       ((r_state == S_ITER) && (isShift(r_op) ? (r_cnt == 4'd0) : w_mdDone));

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_shv     <= '0;
      r_cnt     <= '0;
      r_lastOut <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op    <= s;
          r_a     <= inbus;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_b     <= inbus;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_shv     <= r_b;
          r_cnt     <= r_a[3:0];
          r_lastOut <= 1'b0;
          r_state   <= w_toIter ? S_ITER : S_DONE;
        end
        S_ITER: begin
          if (w_enterDone) begin
            r_state <= S_DONE;
          end else if (isShift(r_op)) begin
            r_shv     <= w_shNext;
            r_lastOut <= w_shOut;
            r_cnt     <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_out <= '0;
      r_n   <= 1'b0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
    end else if (w_enterDone) begin
      r_out <= w_out;
      r_n   <= w_n;
      r_z   <= w_z;
      r_c   <= w_c;
      r_v   <= w_v;
    end
  end

  assign outbus   = r_out;
  assign finish   = (r_state == S_DONE);
  assign negative = r_n;
  assign zero     = r_z;
  assign carry    = r_c;
  assign overflow = r_v;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for the sequential ALU: hand-computed result, NZCV, latency and pulse-width checks.
// Multiply/divide expectations follow the ALU_MULDIV_EN build setting.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [3:0]  s;
  logic [15:0] inbus;
  logic [15:0] outbus;
  logic        finish;
  logic        negative, zero, carry, overflow;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .s        (s),
    .inbus    (inbus),
    .outbus   (outbus),
    .finish   (finish),
    .negative (negative),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives opcode+A, then B, then waits (bounded) for finish; optionally pokes start while busy.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input int poke, output int latency);
    start = 1'b1;
    s     = op;
    inbus = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    inbus = b;
    @(posedge clk);
    latency = 1;
    while (latency < 60) begin
      @(posedge clk);
      latency++;
      #1;
      if (finish) break;
      start = (latency == poke);
      if (latency == poke) begin
        s     = 4'hB;
        inbus = 16'hFFFF;
      end
    end
    start = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int poke, input logic [15:0] expOut, input logic [3:0] expFlags, input int expLat);
    int lat;
    applyStimulus(op, a, b, poke, lat);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " outbus"}, outbus, expOut);
    checkOutput({tag, " nzcv"}, {negative, zero, carry, overflow}, expFlags);
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse"}, finish, 1'b0);
    checkOutput({tag, " hold"}, outbus, expOut);
  endtask

  initial begin
    int  cyc;
    logic sawFinish;
    rst_b = 1'b1;
    start = 1'b0;
    s     = 4'd0;
    inbus = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outbus", outbus, 16'h0000);
    checkOutput("reset nzcv", {negative, zero, carry, overflow}, 4'b0000);
    checkOutput("reset finish", finish, 1'b0);
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    runOp("ADD",     4'd0,  16'd5,      16'd2147,   0, 16'h0868, 4'b0000, 2);
    runOp("ADD ovf", 4'd0,  16'h7FFF,   16'h0001,   0, 16'h8000, 4'b1001, 2);
    runOp("ADD cry", 4'd0,  16'hFFFF,   16'h0001,   0, 16'h0000, 4'b0110, 2);
    runOp("SUB",     4'd1,  16'd5,      16'd2147,   0, 16'hF7A2, 4'b1000, 2);
    runOp("SUB eq",  4'd1,  16'd5,      16'd5,      0, 16'h0000, 4'b0110, 2);
`ifdef ALU_MULDIV_EN
    runOp("MUL",     4'd2,  16'd5,      16'd2147,   0, 16'h29EF, 4'b0000, 19);
    runOp("MUL hi",  4'd2,  16'h1234,   16'h0100,   0, 16'h3400, 4'b0011, 19);
    runOp("DIV",     4'd3,  16'd5,      16'd2147,   0, 16'h0000, 4'b0100, 19);
    runOp("MOD",     4'd4,  16'd5,      16'd2147,   0, 16'h0005, 4'b0000, 19);
    runOp("DIV big", 4'd3,  16'd2147,   16'd5,      0, 16'd429,  4'b0000, 19);
    runOp("MOD big", 4'd4,  16'd2147,   16'd5,      0, 16'd2,    4'b0000, 19);
    runOp("DIV0",    4'd3,  16'd1234,   16'd0,      0, 16'hFFFF, 4'b1001, 19);
    runOp("MOD0",    4'd4,  16'd1234,   16'd0,      0, 16'h04D2, 4'b0001, 19);
`else
    runOp("MUL rsv", 4'd2,  16'd5,      16'd2147,   0, 16'h0000, 4'b0001, 2);
    runOp("DIV rsv", 4'd3,  16'd5,      16'd2147,   0, 16'h0000, 4'b0001, 2);
    runOp("MOD rsv", 4'd4,  16'd1234,   16'd0,      0, 16'h0000, 4'b0001, 2);
`endif
    runOp("LSR",     4'd5,  16'd3,      16'd5324,   0, 16'd665,  4'b0010, 6);
    runOp("LSL",     4'd6,  16'd4,      16'd17,     0, 16'd272,  4'b0000, 7);
    runOp("RSR",     4'd7,  16'd2,      16'd7,      0, 16'hC001, 4'b1010, 5);
    runOp("RSL",     4'd8,  16'd3,      16'd52523,  0, 16'h695E, 4'b0000, 6);
    runOp("LSR cnt0", 4'd5, 16'h0010,   16'h8001,   0, 16'h8001, 4'b1000, 3);
    runOp("AND",     4'd9,  16'd14,     16'd11,     0, 16'd10,   4'b0000, 2);
    runOp("OR",      4'd10, 16'hF000,   16'h000F,   0, 16'hF00F, 4'b1000, 2);
    runOp("XOR",     4'd11, 16'hF3C0,   16'h01EF,   0, 16'hF22F, 4'b1000, 2);
    runOp("NOT",     4'd12, 16'h1234,   16'h0F0F,   0, 16'hF0F0, 4'b1000, 2);
    runOp("CMP",     4'd13, 16'd29,     16'd15,     0, 16'h0000, 4'b0010, 2);
    runOp("TST",     4'd14, 16'h83D9,   16'hAA0C,   0, 16'h0000, 4'b1000, 2);
    runOp("RSV15",   4'd15, 16'hFFFF,   16'hFFFF,   0, 16'h0000, 4'b0000, 2);
    runOp("LSL 15",  4'd6,  16'd15,     16'hFFFF,   0, 16'h8000, 4'b1010, 18);
    runOp("busy start", 4'd6, 16'd4,    16'd17,     3, 16'd272,  4'b0000, 7);

    // Reset in the middle of a long shift: outputs clear at once and the op never finishes.
    start = 1'b1;
    s     = 4'd6;
    inbus = 16'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    inbus = 16'hFFFF;
    repeat (6) @(posedge clk);
    #1;
    rst_b = 1'b1;
    #1;
    checkOutput("midreset outbus", outbus, 16'h0000);
    checkOutput("midreset nzcv", {negative, zero, carry, overflow}, 4'b0000);
    checkOutput("midreset finish", finish, 1'b0);
    #2;
    rst_b = 1'b0;
    sawFinish = 1'b0;
    for (cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk);
      #1;
      if (finish) sawFinish = 1'b1;
    end
    checkOutput("midreset no finish", sawFinish, 1'b0);
    checkOutput("midreset outbus held", outbus, 16'h0000);
    runOp("after reset", 4'd0, 16'd5, 16'd2147, 0, 16'h0868, 4'b0000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
